// File: rtl/handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : handshake_rr_arbiter
// Description : Round-robin arbiter merging N valid/ready requesters into one
//               registered output channel tagged with the source index.
//               Optional burst grants enabled by defining HS_ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_rr_arbiter #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         valid_pre_i,
    input  logic [N*DW-1:0]      data_pre_i,
    output logic [N-1:0]         ready_pre_o,
    output logic                 valid_post_o,
    output logic [DW-1:0]        data_post_o,
    output logic [$clog2(N)-1:0] grant_id_o,
    input  logic                 ready_post_i
);

    localparam int IW = $clog2(N);

    if (N < 2 || N > 16 || BURST < 1) begin : g_param_check
        $error("handshake_rr_arbiter: N must be 2..16 and BURST >= 1");
    end

    logic [IW-1:0] ptr_q, ptr_d;
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [IW-1:0] gid_q;

    logic          free;
    logic          any_valid;
    logic          rr_found;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] winner;
    logic [IW-1:0] winner_inc;
    int            scan_sum;

    assign free       = !valid_q || ready_post_i;
    assign any_valid  = |valid_pre_i;
    assign winner_inc = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_sum = 0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = int'(ptr_q) + k;
            if (scan_sum >= N) begin
                scan_sum = scan_sum - N;
            end
            scan_idx = IW'(scan_sum);
            if (!rr_found && valid_pre_i[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

`ifdef HS_ARB_BURST_EN
    localparam int            BW        = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST);

    logic [BW-1:0] burst_q, burst_d;
    logic          keep;

    // A zero count means no owner yet, so the first grant after reset is plain round-robin.
    assign keep    = (burst_q != '0) && (burst_q < BURST_MAX) && valid_pre_i[gid_q];
    assign winner  = keep ? gid_q : rr_idx;
    assign burst_d = keep ? burst_q + 1'b1 : BW'(1);
    assign ptr_d   = keep ? ptr_q : winner_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else if (free && any_valid) begin
            burst_q <= burst_d;
        end
    end
`else
    assign winner = rr_idx;
    assign ptr_d  = winner_inc;
`endif

    always_comb begin
        ready_pre_o = '0;
        if (!rst && free && any_valid) begin
            ready_pre_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
        end else if (free) begin
            if (any_valid) begin
                valid_q <= 1'b1;
                data_q  <= data_pre_i[winner*DW +: DW];
                gid_q   <= winner;
                ptr_q   <= ptr_d;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_post_o = valid_q;
    assign data_post_o  = data_q;
    assign grant_id_o   = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_rr_arbiter
// Description : Directed self-checking bench for handshake_rr_arbiter (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid_pre;
    logic [N*DW-1:0] data_pre;
    logic [N-1:0]    ready_pre;
    logic            valid_post;
    logic [DW-1:0]   data_post;
    logic [1:0]      grant_id;
    logic            ready_post;

    int test_cnt = 0;
    int fail_cnt = 0;

    handshake_rr_arbiter #(.N(N), .DW(DW), .BURST(3)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .valid_pre_i  (valid_pre),
        .data_pre_i   (data_pre),
        .ready_pre_o  (ready_pre),
        .valid_post_o (valid_post),
        .data_post_o  (data_post),
        .grant_id_o   (grant_id),
        .ready_post_i (ready_post)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int gid);
        check_eq({tag, "_valid"}, 32'(valid_post), 32'd1);
        check_eq({tag, "_gid"}, 32'(grant_id), 32'(gid));
        check_eq({tag, "_data"}, 32'(data_post), 32'(8'h10 + gid));
    endtask

`ifdef HS_ARB_BURST_EN
    int burst_seq[7] = '{0, 0, 0, 1, 2, 2, 2};
`else
    int sparse_seq[4] = '{3, 1, 3, 1};
`endif

    initial begin
        rst        = 1'b1;
        valid_pre  = '0;
        ready_post = 1'b1;
        data_pre   = {8'h13, 8'h12, 8'h11, 8'h10};

        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq("rst_valid", 32'(valid_post), 32'd0);
            check_eq("rst_data", 32'(data_post), 32'd0);
            check_eq("rst_gid", 32'(grant_id), 32'd0);
            check_eq("rst_ready", 32'(ready_pre), 32'd0);
        end
        rst = 1'b0;
        #1;
        check_eq("idle_ready", 32'(ready_pre), 32'd0);
        tick();
        check_eq("idle_valid", 32'(valid_post), 32'd0);

`ifdef HS_ARB_BURST_EN
        valid_pre = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_beat("burst_all", i / 3);
        end
        rst = 1'b1;
        tick();
        check_eq("burst_rst_valid", 32'(valid_post), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_beat("burst_drop", burst_seq[i]);
            if (i == 3) valid_pre = 4'b1101;
        end
`else
        // Full contention: strict rotation with ptr wrap and no bubbles.
        valid_pre = 4'hF;
        #1;
        check_eq("fc_ready0", 32'(ready_pre), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_beat("fc", i % 4);
            check_eq("fc_ready", 32'(ready_pre), 32'd1 << ((i + 1) % 4));
        end

        // Backpressure holds the beat and blocks all requesters.
        ready_post = 1'b0;
        #1;
        check_eq("bp_ready", 32'(ready_pre), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_beat("bp_hold", 3);
            check_eq("bp_ready_hold", 32'(ready_pre), 32'd0);
        end
        ready_post = 1'b1;
        #1;
        check_eq("bp_resume_ready", 32'(ready_pre), 32'd1);
        tick();
        check_beat("bp_resume", 0);

        // Sparse: requester 2 present once then withdrawn without a grant.
        valid_pre = 4'b1110;
        #1;
        check_eq("sp_ready", 32'(ready_pre), 32'b0010);
        tick();
        check_beat("sp_first", 1);
        valid_pre = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_beat("sp", sparse_seq[i]);
        end

        // Single requester 0 while ptr points at 2.
        valid_pre = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_beat("single", 0);
        end

        // Free with no requests: valid drops, data and id hold.
        valid_pre = '0;
        tick();
        check_eq("drain_valid", 32'(valid_post), 32'd0);
        check_eq("drain_data", 32'(data_post), 32'h10);
        check_eq("drain_gid", 32'(grant_id), 32'd0);

        // Reset while a beat is stalled in the output register.
        valid_pre  = 4'b0100;
        ready_post = 1'b0;
        tick();
        check_beat("mid_load", 2);
        valid_pre = '0;
        tick();
        check_beat("mid_stall", 2);
        rst       = 1'b1;
        valid_pre = 4'hF;
        #1;
        check_eq("mid_rst_ready", 32'(ready_pre), 32'd0);
        tick();
        check_eq("mid_rst_valid", 32'(valid_post), 32'd0);
        check_eq("mid_rst_data", 32'(data_post), 32'd0);
        check_eq("mid_rst_gid", 32'(grant_id), 32'd0);
        rst        = 1'b0;
        ready_post = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'(ready_pre), 32'd1);
        tick();
        check_beat("post_rst", 0);
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/handshake_rr_arbiter.md
# handshake_rr_arbiter

- Round-robin arbiter that shares one downstream valid/ready channel among N upstream valid/ready requesters.
- Each accepted beat is registered in a single output stage: 1-cycle latency, one beat per cycle sustained throughput.
- Sits between several producer handshake stages and a single consumer stage. Tags each output beat with its source index.

## Interface
Parameters:
- N, default 4: number of requesters, 2..16.
- DW, default 8: data width per beat.
- BURST, default 4: maximum consecutive grants to one requester. Used only with HS_ARB_BURST_EN.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- valid_pre_i  input  N  per-requester valid; bit i = requester i.
- data_pre_i  input  N*DW  per-requester data; requester i on bits [i*DW +: DW].
- ready_pre_o  output  N  per-requester ready; at most one bit set.
- valid_post_o  output  1  output beat valid.
- data_post_o  output  DW  output beat data.
- grant_id_o  output  clog2(N)  index of the requester that produced the current output beat.
- ready_post_i  input  1  downstream ready.

## Operation
- Output register is free when !valid_post_o || ready_post_i.
- Winner, combinational: first requester with valid_pre_i set, scanning from ptr upward and wrapping modulo N.
- ready_pre_o[i] = free && (winner == i) && valid_pre_i[i].
  - ready may depend on valid; valid never depends on ready.
- Accept happens when free and any valid_pre_i is set. On accept:
  - data_post_o <= winner's data.
  - valid_post_o <= 1.
  - grant_id_o <= winner.
  - ptr <= (winner + 1) mod N.
- When free and no valid_pre_i is set: valid_post_o <= 0. data_post_o and grant_id_o hold their last values.
- When not free (valid_post_o && !ready_post_i): all ready_pre_o are 0. Output register, ptr and burst count hold.
- Downstream drain and a new accept in the same cycle are allowed. This gives back-to-back beats with no bubble.
- Requester protocol: once asserted, valid_pre_i/data_pre_i are held until ready. The arbiter does not enforce this.
- A requester dropping valid without being granted forfeits its turn. No state is recorded for it.
- Fairness: with all N requesters valid continuously, grants rotate 0,1,...,N-1,0,... Each requester is served once per N accepts.

## Timing
- Latency: a beat accepted at edge k is visible on valid_post_o/data_post_o after edge k.
- Reset values: valid_post_o=0, data_post_o=0, grant_id_o=0, ptr=0, burst count=0. ready_pre_o=0 while rst is high.
- Reset mid-operation drops any beat held in the output register. No beat is delivered after rst.
- Reset out of idle: the first cycle after rst deasserts, requester 0 has priority.
- Single active requester: granted every free cycle, regardless of ptr.
- ptr wrap: winner N-1 sets ptr to 0.

## Configuration
- HS_ARB_BURST_EN defined:
  - A burst counter (1..BURST) tracks consecutive accepts by the current grant_id_o owner.
  - If the owner's valid is still set and the count is below BURST, the owner wins again. ptr does not advance; count increments.
  - When the count reaches BURST, or the owner's valid drops, normal round-robin resumes from owner+1 and the count restarts at 1 for the new winner.
  - BURST=1 behaves identically to the macro being undefined.
- HS_ARB_BURST_EN undefined:
  - Strict per-beat round-robin as in Operation.
  - No counter logic is synthesized.

## Test plan
- Reset then idle: rst high 2 cycles, all valid 0 -> valid_post_o=0, data_post_o=0, grant_id_o=0, ready_pre_o=0 throughout.
- Full contention: N=4, all valid, data i = 0x10+i, ready_post_i=1 for 8 cycles -> outputs 0x10,0x11,0x12,0x13,0x10,...; grant_id 0,1,2,3,0,...; no bubbles.
- Backpressure: a beat is in the output, ready_post_i=0 for 3 cycles -> valid_post_o/data_post_o stable, all ready_pre_o=0. After ready returns, the next winner follows ptr order.
- Sparse requests: only requesters 1 and 3 valid, ready_post_i=1 -> grant sequence 1,3,1,3. Requester 2 dropping valid early leaves no trace.
- Reset mid-stream: rst asserted while valid_post_o=1 with ready_post_i=0 -> next cycle valid_post_o=0; after release, requester 0 wins first.
- HS_ARB_BURST_EN with BURST=3, all valid -> grant sequence 0,0,0,1,1,1,2,2,2,3,3,3. With requester 1 dropping valid after 1 beat -> 0,0,0,1,2,2,2.
